// File: rtl/pool_window_ctrl.sv
// Frame sequencer for the max-pooling window datapath: handshakes the raster pixel
// stream, tracks row/column position and flags stride-aligned, fully-inside windows.
module pool_window_ctrl #(
  parameter int KERNEL_DIM = 3,
  parameter int ROW_SIZE   = 5,
  parameter int COL_SIZE   = 5,
  parameter int STRIDE     = 2,
  localparam int OUT_W = (ROW_SIZE - KERNEL_DIM) / STRIDE + 1,
  localparam int OUT_H = (COL_SIZE - KERNEL_DIM) / STRIDE + 1,
  localparam int OCW   = (OUT_W > 1) ? $clog2(OUT_W) : 1,
  localparam int ORW   = (OUT_H > 1) ? $clog2(OUT_H) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           in_valid,
  output logic           in_ready,
  output logic           shift_en,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [ORW-1:0] out_row,
  output logic [OCW-1:0] out_col,
  output logic           out_last,
  output logic           busy,
  output logic           frame_done
);

  localparam int CW = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;
  localparam int RW = (COL_SIZE > 1) ? $clog2(COL_SIZE) : 1;
  localparam int PW = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  localparam logic [CW-1:0]  COL_LAST  = CW'(ROW_SIZE - 1);
  localparam logic [RW-1:0]  ROW_LAST  = RW'(COL_SIZE - 1);
  localparam logic [CW-1:0]  COL_FIRST = CW'(KERNEL_DIM - 1);
  localparam logic [RW-1:0]  ROW_FIRST = RW'(KERNEL_DIM - 1);
  localparam logic [PW-1:0]  PH_LAST   = PW'(STRIDE - 1);
  localparam logic [PW-1:0]  PH_ZERO   = {PW{1'b0}};
  localparam logic [OCW-1:0] OW_LAST   = OCW'(OUT_W - 1);
  localparam logic [ORW-1:0] OH_LAST   = ORW'(OUT_H - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t          state_r, state_s;
  logic [CW-1:0]   col_r, col_next_s;
  logic [RW-1:0]   row_r, row_next_s;
  logic [PW-1:0]   col_ph_r, row_ph_r;
  logic [OCW-1:0]  col_idx_r;
  logic [ORW-1:0]  row_idx_r;
  logic            out_valid_r, out_last_r;
  logic [ORW-1:0]  out_row_r;
  logic [OCW-1:0]  out_col_r;
  logic            accept_s, qualify_s, col_wrap_s, frame_end_s, in_ready_s;

  // Handshake, window qualification and next-state decode
  always_comb begin
    state_s     = state_r;
    in_ready_s  = (state_r == RUN) && !(out_valid_r && !out_ready);
    accept_s    = in_valid && in_ready_s;
    col_wrap_s  = (col_r == COL_LAST);
    frame_end_s = accept_s && col_wrap_s && (row_r == ROW_LAST);
    col_next_s  = col_wrap_s ? {CW{1'b0}} : col_r + CW'(1);
    row_next_s  = row_r + RW'(1);
    qualify_s   = accept_s && (row_r >= ROW_FIRST) && (col_r >= COL_FIRST) &&
                  (row_ph_r == PH_ZERO) && (col_ph_r == PH_ZERO);
    case (state_r)
      IDLE:    if (start) state_s = RUN; else state_s = IDLE;
      RUN:     if (frame_end_s) state_s = DRAIN; else state_s = RUN;
      DRAIN:   if (!out_valid_r || out_ready) state_s = DONE; else state_s = DRAIN;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_s;
  end

  // Position counters; phase/index restart whenever the position re-enters the first legal window
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_r     <= {CW{1'b0}};
      row_r     <= {RW{1'b0}};
      col_ph_r  <= PH_ZERO;
      row_ph_r  <= PH_ZERO;
      col_idx_r <= {OCW{1'b0}};
      row_idx_r <= {ORW{1'b0}};
    end else if ((state_r == IDLE && start) || state_r == DONE || frame_end_s) begin
      col_r     <= {CW{1'b0}};
      row_r     <= {RW{1'b0}};
      col_ph_r  <= PH_ZERO;
      row_ph_r  <= PH_ZERO;
      col_idx_r <= {OCW{1'b0}};
      row_idx_r <= {ORW{1'b0}};
    end else if (accept_s) begin
      col_r <= col_next_s;
      if (col_next_s <= COL_FIRST) begin
        col_ph_r  <= PH_ZERO;
        col_idx_r <= {OCW{1'b0}};
      end else if (col_ph_r == PH_LAST) begin
        col_ph_r  <= PH_ZERO;
        col_idx_r <= col_idx_r + OCW'(1);
      end else begin
        col_ph_r  <= col_ph_r + PW'(1);
      end
      if (col_wrap_s) begin
        row_r <= row_next_s;
        if (row_next_s <= ROW_FIRST) begin
          row_ph_r  <= PH_ZERO;
          row_idx_r <= {ORW{1'b0}};
        end else if (row_ph_r == PH_LAST) begin
          row_ph_r  <= PH_ZERO;
          row_idx_r <= row_idx_r + ORW'(1);
        end else begin
          row_ph_r  <= row_ph_r + PW'(1);
        end
      end
    end
  end

  // Window-valid register: a fresh qualifying accept wins over a same-cycle consume
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_row_r   <= {ORW{1'b0}};
      out_col_r   <= {OCW{1'b0}};
    end else if (state_r == DONE) begin
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_row_r   <= {ORW{1'b0}};
      out_col_r   <= {OCW{1'b0}};
    end else if (qualify_s) begin
      out_valid_r <= 1'b1;
      out_row_r   <= row_idx_r;
      out_col_r   <= col_idx_r;
      out_last_r  <= (row_idx_r == OH_LAST) && (col_idx_r == OW_LAST);
    end else if (out_valid_r && out_ready) begin
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
    end
  end

  assign in_ready   = in_ready_s;
  assign shift_en   = accept_s;
  assign out_valid  = out_valid_r;
  assign out_row    = out_row_r;
  assign out_col    = out_col_r;
  assign out_last   = out_last_r;
  assign busy       = (state_r != IDLE);
  assign frame_done = (state_r == DONE);

endmodule

// File: tb/tb_pool_window_ctrl.sv
// Directed bench for pool_window_ctrl (3x3 kernel, 5x5 frame, stride 2).
module tb_pool_window_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic       in_ready, shift_en, out_valid, out_last, busy, frame_done;
  logic [0:0] out_row, out_col;

  int n_tests = 0;
  int n_fail  = 0;

  // Hand-computed windows: accept index, pooled row, pooled col, last flag
  int exp_acc [4] = '{12, 14, 22, 24};
  int exp_row [4] = '{0, 0, 1, 1};
  int exp_col [4] = '{0, 1, 0, 1};
  int exp_last[4] = '{0, 0, 0, 1};

  pool_window_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .shift_en(shift_en), .out_valid(out_valid), .out_ready(out_ready),
    .out_row(out_row), .out_col(out_col), .out_last(out_last),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_start();
    @(posedge clk); #1;
    in_valid = 1'b1; start = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("idle_in_ready", in_ready, 0);
    check("idle_shift", shift_en, 0);
    check("idle_busy", busy, 0);
    @(posedge clk); #1;
    start = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("run_busy", busy, 1);
    check("run_noval_shift", shift_en, 0);
    check("run_in_ready", in_ready, 1);
    @(posedge clk); #1;
  endtask

  task automatic run_frame(input bit toggle, input int bp, input bit mid_start);
    int k = 0, n_sh = 0, bp_left = bp, hs_cyc = -10;
    bit prev_sh = 1'b0, done_seen = 1'b0;
    do_start();
    for (int cyc = 0; cyc < 300 && !done_seen; cyc++) begin
      in_valid  = toggle ? (cyc % 2 == 0) : 1'b1;
      start     = mid_start && (cyc == 20);
      out_ready = 1'b1;
      if (bp_left > 0 && out_valid && k == 0) begin
        out_ready = 1'b0;
        bp_left--;
      end
      @(negedge clk);
      if (!out_ready) begin
        check("bp_in_ready", in_ready, 0);
        check("bp_shift", shift_en, 0);
        check("bp_valid", out_valid, 1);
        check("bp_row", out_row, 0);
        check("bp_col", out_col, 0);
      end
      if (toggle && !in_valid) check("tog_shift", shift_en, 0);
      if (prev_sh && (n_sh - 1 == 10 || n_sh - 1 == 11)) check("wrap_no_valid", out_valid, 0);
      if (out_valid && out_ready) begin
        if (k < 4) begin
          check("win_acc", n_sh - 1, exp_acc[k]);
          check("win_row", out_row, exp_row[k]);
          check("win_col", out_col, exp_col[k]);
          check("win_last", out_last, exp_last[k]);
          if (bp == 0) check("win_latency", prev_sh, 1);
        end else begin
          check("extra_window", k, 3);
        end
        k++;
        hs_cyc = cyc;
      end
      if (frame_done) begin
        check("done_latency", cyc, hs_cyc + 1);
        check("done_busy", busy, 1);
        done_seen = 1'b1;
      end
      if (shift_en) n_sh++;
      prev_sh = shift_en;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; start = 1'b0; out_ready = 1'b1;
    check("done_seen", done_seen, 1);
    check("shift_total", n_sh, 25);
    check("window_total", k, 4);
    @(negedge clk);
    check("done_pulse_len", frame_done, 0);
    check("busy_after", busy, 0);
    check("valid_after", out_valid, 0);
  endtask

  initial begin
    int n_sh;
    bit got_win;
    #12;
    @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", frame_done, 0);
    check("rst_row", out_row, 0);
    check("rst_col", out_col, 0);
    check("rst_last", out_last, 0);
    check("rst_in_ready", in_ready, 0);
    rst = 1'b0;

    run_frame(1'b0, 0, 1'b0);   // continuous stream
    run_frame(1'b0, 5, 1'b0);   // 5-cycle stall on first window
    run_frame(1'b1, 0, 1'b1);   // every-other-cycle input, start pulsed mid-frame

    // Freeze on first window, then assert reset asynchronously
    do_start();
    n_sh = 0;
    got_win = 1'b0;
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 100 && !got_win; cyc++) begin
      in_valid = 1'b1;
      @(negedge clk);
      if (out_valid) got_win = 1'b1;
      else if (shift_en) n_sh++;
      if (!got_win) begin
        @(posedge clk); #1;
      end
    end
    check("pre_rst_window", got_win, 1);
    check("pre_rst_shifts", n_sh, 13);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_in_ready", in_ready, 0);
    check("arst_shift", shift_en, 0);
    check("arst_row", out_row, 0);
    check("arst_col", out_col, 0);
    check("arst_last", out_last, 0);
    check("arst_done", frame_done, 0);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    run_frame(1'b0, 0, 1'b0);   // must reproduce the first frame

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pool_window_ctrl.md
Name: pool_window_ctrl

Overview:
- Frame-level sequencer for the max-pooling sliding-window datapath.
- Accepts a raster pixel stream with a valid/ready handshake and emits one shift strobe per accepted pixel to advance the window/line buffer.
- Tracks row and column of each pixel. Flags only windows that lie fully inside one frame row span and fall on the pooling stride grid.
- Applies downstream backpressure and signals frame completion.

Parameters:
- KERNEL_DIM, 3: pooling window edge, in pixels.
- ROW_SIZE, 5: pixels per image row.
- COL_SIZE, 5: rows per frame.
- STRIDE, 2: pooling stride, applied in both dimensions.
- Derived: OUT_W = (ROW_SIZE-KERNEL_DIM)/STRIDE+1, OUT_H = (COL_SIZE-KERNEL_DIM)/STRIDE+1.
- Legal range: KERNEL_DIM <= ROW_SIZE, KERNEL_DIM <= COL_SIZE, STRIDE >= 1.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: asynchronous active-high reset.
- start, input, 1: begins a frame; sampled only in IDLE.
- in_valid, input, 1: upstream pixel available.
- in_ready, output, 1: controller accepts a pixel this cycle.
- shift_en, output, 1: advance window datapath by one pixel; equals in_valid & in_ready (combinational).
- out_valid, output, 1: window datapath currently holds a legal pooling window.
- out_ready, input, 1: downstream consumes the window.
- out_row, output, max(1,$clog2(OUT_H)): pooled-output row index of the current window.
- out_col, output, max(1,$clog2(OUT_W)): pooled-output column index.
- out_last, output, 1: current window is the final pooled output of the frame.
- busy, output, 1: state != IDLE.
- frame_done, output, 1: one-cycle pulse at end of frame.

Behaviour:
- Reset (async, any state): state=IDLE; counters=0; out_valid, out_row, out_col, out_last, frame_done=0.
- State IDLE:
  - in_ready=0.
  - start=1 moves to RUN and clears the row, column and phase counters.
- State RUN:
  - in_ready = !(out_valid & !out_ready).
  - On accept (shift_en=1), col increments; at ROW_SIZE-1 it wraps to 0 and row increments.
  - Accepting pixel (row=COL_SIZE-1, col=ROW_SIZE-1) moves to DRAIN.
- Window qualification is evaluated on the accepted pixel at (r,c):
  - qualifies iff r>=KERNEL_DIM-1, c>=KERNEL_DIM-1, (r-KERNEL_DIM+1)%STRIDE==0 and (c-KERNEL_DIM+1)%STRIDE==0.
  - Implement with phase counters, not dividers.
- out_valid is registered:
  - set on the edge after a qualifying accept (latency 1, aligned with the datapath's updated window);
  - cleared on the edge where out_valid & out_ready, unless a new qualifying accept occurs the same cycle (then it stays 1 with new indices).
- out_row/out_col:
  - out_row = (r-KERNEL_DIM+1)/STRIDE and out_col = (c-KERNEL_DIM+1)/STRIDE, maintained as counters;
  - held stable while out_valid & !out_ready.
- out_last: 1 with the window where out_row=OUT_H-1 and out_col=OUT_W-1.
- Backpressure:
  - while out_valid & !out_ready, in_ready=0 and shift_en=0, so the window is frozen;
  - out_valid, out_row, out_col and out_last must not change.
- Non-qualifying accepts (row wrap-around windows, off-stride positions, first KERNEL_DIM-1 rows) never raise out_valid.
- State DRAIN:
  - in_ready=0;
  - when !out_valid or (out_valid & out_ready), go to DONE.
- State DONE:
  - frame_done=1 for exactly one cycle; counters cleared; go to IDLE.
  - start in DONE is ignored.
- start while busy is ignored.
- in_valid while not RUN is ignored; no shift_en.
- Reset mid-frame:
  - immediate return to IDLE with all outputs 0;
  - the datapath must also be reset by the integration.
- Widths: counters sized $clog2(ROW_SIZE) / $clog2(COL_SIZE), minimum 1 bit, with no overflow at the terminal values.

Test Plan:
- Defaults, start, then 25 pixels with in_valid=1 and out_ready=1:
  - exactly 4 out_valid pulses, one cycle after accepts 12, 14, 22, 24 (0-based);
  - (out_row,out_col) = (0,0), (0,1), (1,0), (1,1);
  - out_last only on the 4th;
  - frame_done 1 cycle after the final handshake; busy falls with it.
- Same stream with out_ready=0 for 5 cycles at the first window:
  - in_ready=0 and shift_en=0 throughout;
  - out_valid and out_row/out_col held;
  - resumes with correct later outputs; exactly 25 shift_en pulses total.
- in_valid toggling every other cycle:
  - outputs identical to the continuous case;
  - shift_en only on accepted cycles.
- Accepts at pixel 10 (row 2, col 0) and 11 (row 2, col 1), which span a row wrap: no out_valid.
- start pulsed during RUN: no effect on counters or outputs. start pulsed in IDLE with in_valid=0: RUN, no shift_en.
- rst asserted asynchronously after pixel 13 with out_valid=1:
  - all outputs 0 immediately, state IDLE;
  - a subsequent full frame reproduces the first scenario exactly.
